operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Input-side front end for the 4-bit ALU datapath.
- The display path turns a two's-complement result into a sign plus a magnitude digit. This block does the reverse: the user enters a sign switch plus a magnitude on the switches, and the block produces two's-complement operands.
- Sequences entry of A, B and opc using a debounced "next" button, then presents them with a valid flag to the ALU instance in top.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (buttons and switches); minimum 2.
- DB_CYCLES, 16, consecutive stable synchronized cycles required before a button level change is accepted; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- sw  input  4  magnitude entry (sw[2:0] also used as opcode)
- sw_neg  input  1  sign switch, 1 = negative
- btn_next  input  1  raw "next" pushbutton, active-high, asynchronous to clk
- btn_clr  input  1  raw "clear" pushbutton, active-high, asynchronous to clk
- A  output  4  operand A, two's complement
- B  output  4  operand B, two's complement
- opc  output  3  ALU opcode
- valid  output  1  high while A, B and opc form a complete entry
- err  output  1  last entry attempt was rejected as out of range
- phase  output  2  current state: 0=ENTER_A, 1=ENTER_B, 2=ENTER_OP, 3=READY

Behaviour:
- Reset, asynchronous: A=0, B=0, opc=0, valid=0, err=0, phase=ENTER_A; all synchronizer and debounce state cleared, debounced levels=0.
- Synchronizers: sw, sw_neg, btn_next and btn_clr each pass through SYNC_STAGES flops. Switches are not debounced.
- Debounce, per button:
  - A counter increments while the synchronized level differs from the debounced level; it resets to 0 when they are equal.
  - When the counter reaches DB_CYCLES, the debounced level flips and the counter clears.
  - A press is a 1-cycle pulse on a debounced 0->1 transition. Releases generate nothing.
  - A held button yields exactly one press.
- Latency: a raw 0->1 level held steady updates the outputs SYNC_STAGES+DB_CYCLES+1 clock edges after the first edge that samples it (±1 edge tolerance for the bench).
- Conversion, using the synchronized sw=m and sw_neg=s at the press cycle:
  - s=0: legal for m 0..7; value = m.
  - s=1: legal for m 0..8; value = (~m + 1) mod 16. -0 yields 0; -8 yields 4'b1000.
  - Anything else is illegal.
- State machine, on a next press (clr press absent):
  - ENTER_A: legal -> A=value, err=0, go to ENTER_B. Illegal -> err=1, stay; A unchanged.
  - ENTER_B: same rules, writing B; legal -> go to ENTER_OP.
  - ENTER_OP: opc=sw[2:0]; sw[3] and sw_neg are ignored. err=0, valid=1, go to READY. Always legal.
  - READY: valid=0, go to ENTER_A. A, B and opc keep their values until overwritten.
- Clear press, in any state: A=0, B=0, opc=0, valid=0, err=0, phase=ENTER_A.
- Clear and next presses in the same cycle: clear wins and the next press is discarded.
- valid is high only in READY. err is only ever set in ENTER_A or ENTER_B.
- Outputs are registered, with no combinational path from inputs.
- Reset asserted mid-debounce or mid-entry: immediate return to reset values. A button still held at deassertion produces one press once debounced.
- Raw glitches shorter than DB_CYCLES synchronized cycles produce no press.

Test Plan:
- Reset, then check idle outputs. Then enter A=+5 (sw=5, neg=0), B=-3 (sw=3, neg=1), op=3 -> A=4'b0101, B=4'b1101, opc=3, valid=1, phase=3, err=0.
- Boundary values:
  - A=-8 (sw=8, neg=1) -> A=4'b1000.
  - B=-0 -> B=0.
  - A=+8 (sw=8, neg=0) -> err=1, phase stays 0, A unchanged. A following legal +7 -> A=4'b0111, err=0.
- Bounce: btn_next toggles every 3 cycles for 40 cycles, then holds high for 100 cycles, with DB_CYCLES=16 -> exactly one phase advance. A press shorter than 10 cycles -> no advance.
- Clear priority: in ENTER_OP, drive clr and next pulses that debounce on the same cycle -> phase=0, A=B=opc=0, valid=0.
- From READY, press next -> valid=0, phase=0, A/B/opc retained. Hold next for 500 cycles -> only one transition.
- Assert rst while in ENTER_B with a button mid-debounce -> all outputs return to 0 immediately. After release, the button still held -> exactly one press.

Source files
------------

// File: rtl/operand_entry.sv
// operand_entry: switch/button front end for the 4-bit ALU.
// Synchronizes the raw switches and buttons, debounces the two buttons,
// converts sign+magnitude entries to two's complement, and steps through
// A -> B -> opcode -> READY on each debounced "next" press.
module operand_entry #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       sw_neg,
    input  logic       btn_next,
    input  logic       btn_clr,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] opc,
    output logic       valid,
    output logic       err,
    output logic [1:0] phase
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    localparam logic [1:0] ST_ENTER_A  = 2'd0;
    localparam logic [1:0] ST_ENTER_B  = 2'd1;
    localparam logic [1:0] ST_ENTER_OP = 2'd2;
    localparam logic [1:0] ST_READY    = 2'd3;

    // Raw inputs packed as {btn_clr, btn_next, sw_neg, sw[3:0]}
    logic [6:0] raw;
    logic [6:0] sync_q [SYNC_STAGES];

    logic [3:0] sw_s;
    logic       neg_s;
    logic [1:0] btn_s;            // [0]=next, [1]=clr

    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       db_q, db_d;
    logic [1:0]       press_q, press_d;

    logic [1:0] phase_q, phase_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [2:0] opc_q, opc_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic [3:0] conv_val;
    logic       conv_legal;

    // Sign+magnitude to two's complement; legal range is -8..+7.
    function automatic logic [4:0] convert(input logic [3:0] m, input logic s);
        logic [3:0] neg_m;
        logic       legal;
        neg_m = ~m + 4'd1;
        legal = s ? (m <= 4'd8) : (m <= 4'd7);
        return {legal, (s ? neg_m : m)};
    endfunction

    assign raw   = {btn_clr, btn_next, sw_neg, sw};
    assign sw_s  = sync_q[SYNC_STAGES-1][3:0];
    assign neg_s = sync_q[SYNC_STAGES-1][4];
    assign btn_s = sync_q[SYNC_STAGES-1][6:5];

    assign {conv_legal, conv_val} = convert(sw_s, neg_s);

    // Multi-flop synchronizer chain for every raw input bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Debounce: a level change is accepted after DB_CYCLES stable cycles;
    // only an accepted 0->1 change produces a one-cycle press.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]   = '0;
            db_d[i]    = db_q[i];
            press_d[i] = 1'b0;
            if (btn_s[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                    db_d[i]    = btn_s[i];
                    press_d[i] = btn_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            db_q     <= '0;
            press_q  <= '0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            db_q     <= db_d;
            press_q  <= press_d;
        end
    end

    // Entry sequencer; a clear press overrides a simultaneous next press
    always_comb begin
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (press_q[1]) begin
            phase_d = ST_ENTER_A;
            a_d     = 4'd0;
            b_d     = 4'd0;
            opc_d   = 3'd0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (press_q[0]) begin
            case (phase_q)
                ST_ENTER_A: begin
                    if (conv_legal) begin
                        a_d     = conv_val;
                        err_d   = 1'b0;
                        phase_d = ST_ENTER_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_ENTER_B: begin
                    if (conv_legal) begin
                        b_d     = conv_val;
                        err_d   = 1'b0;
                        phase_d = ST_ENTER_OP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_ENTER_OP: begin
                    opc_d   = sw_s[2:0];
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    phase_d = ST_READY;
                end
                default: begin
                    valid_d = 1'b0;
                    phase_d = ST_ENTER_A;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= ST_ENTER_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            opc_q   <= 3'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign opc   = opc_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: table-driven entry sequence, hand-written
// debounce/clear/reset corner cases, and randomized entries checked
// against a press-level reference model.
module tb_operand_entry;

    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       sw_neg;
    logic       btn_next;
    logic       btn_clr;
    logic [3:0] A, B;
    logic [2:0] opc;
    logic       valid, err;
    logic [1:0] phase;

    int total = 0;
    int bad   = 0;
    int changes;
    logic [1:0] last_ph;

    // reference model state
    logic [3:0] mA, mB;
    logic [2:0] mop;
    logic       mv, me;
    logic [1:0] mph;

    typedef struct {
        int         kind;   // 0 = next press, 1 = clear press
        logic [3:0] sw;
        logic       neg;
        logic [3:0] eA;
        logic [3:0] eB;
        logic [2:0] eop;
        logic       ev;
        logic       ee;
        logic [1:0] eph;
    } vec_t;

    vec_t vecs [12];

    operand_entry #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) dut (
        .clk(clk), .rst(rst), .sw(sw), .sw_neg(sw_neg),
        .btn_next(btn_next), .btn_clr(btn_clr),
        .A(A), .B(B), .opc(opc), .valid(valid), .err(err), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eA, input logic [3:0] eB,
                             input logic [2:0] eop, input logic ev, input logic ee,
                             input logic [1:0] eph);
        check({tag, ".A"}, 32'(A), 32'(eA));
        check({tag, ".B"}, 32'(B), 32'(eB));
        check({tag, ".opc"}, 32'(opc), 32'(eop));
        check({tag, ".valid"}, 32'(valid), 32'(ev));
        check({tag, ".err"}, 32'(err), 32'(ee));
        check({tag, ".phase"}, 32'(phase), 32'(eph));
    endtask

    // advance one clock, sample 1 time unit after the edge, count phase changes
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (phase !== last_ph) changes++;
            last_ph = phase;
        end
    endtask

    task automatic press(input logic nxt, input logic clr, input int hold);
        btn_next = nxt;
        btn_clr  = clr;
        step(hold);
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        step(30);
    endtask

    // press-level reference: apply one debounced press to the model
    task automatic model_press(input logic nxt, input logic clr, input logic [3:0] m, input logic s);
        int  val;
        bit  legal;
        legal = s ? (m <= 8) : (m <= 7);
        val   = s ? ((16 - int'(m)) % 16) : int'(m);
        if (clr) begin
            mA = 0; mB = 0; mop = 0; mv = 0; me = 0; mph = 0;
        end else if (nxt) begin
            if (mph == 0 || mph == 1) begin
                if (legal) begin
                    if (mph == 0) mA = 4'(val); else mB = 4'(val);
                    me  = 0;
                    mph = mph + 1;
                end else begin
                    me = 1;
                end
            end else if (mph == 2) begin
                mop = m[2:0]; me = 0; mv = 1; mph = 3;
            end else begin
                mv = 0; mph = 0;
            end
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{0, 4'd5,  1'b0, 4'b0101, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd1};
        vecs[1]  = '{0, 4'd3,  1'b1, 4'b0101, 4'b1101, 3'd0, 1'b0, 1'b0, 2'd2};
        vecs[2]  = '{0, 4'd3,  1'b0, 4'b0101, 4'b1101, 3'd3, 1'b1, 1'b0, 2'd3};
        vecs[3]  = '{0, 4'd0,  1'b0, 4'b0101, 4'b1101, 3'd3, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{0, 4'd8,  1'b1, 4'b1000, 4'b1101, 3'd3, 1'b0, 1'b0, 2'd1};
        vecs[5]  = '{0, 4'd0,  1'b1, 4'b1000, 4'b0000, 3'd3, 1'b0, 1'b0, 2'd2};
        vecs[6]  = '{0, 4'd14, 1'b1, 4'b1000, 4'b0000, 3'd6, 1'b1, 1'b0, 2'd3};
        vecs[7]  = '{0, 4'd0,  1'b0, 4'b1000, 4'b0000, 3'd6, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{0, 4'd8,  1'b0, 4'b1000, 4'b0000, 3'd6, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{0, 4'd7,  1'b0, 4'b0111, 4'b0000, 3'd6, 1'b0, 1'b0, 2'd1};
        vecs[10] = '{0, 4'd9,  1'b1, 4'b0111, 4'b0000, 3'd6, 1'b0, 1'b1, 2'd1};
        vecs[11] = '{1, 4'd0,  1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0, 2'd0};

        rst = 1'b1; sw = 4'd0; sw_neg = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
        changes = 0; last_ph = 2'd0;
        step(3);
        rst = 1'b0;
        step(2);
        check_all("reset", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // latency of a clean press, counted in edges from the first sampling edge
        sw = 4'd1; sw_neg = 1'b0;
        btn_next = 1'b1;
        n = 0;
        while (phase == 2'd0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        last_ph = phase;
        check("latency_in_range", 32'((n >= SYNC_STAGES + DB_CYCLES + 1) &&
                                      (n <= SYNC_STAGES + DB_CYCLES + 3)), 32'd1);
        btn_next = 1'b0;
        step(30);
        check("latency.A", 32'(A), 32'd1);
        press(1'b0, 1'b1, 25);
        check_all("clr1", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // table-driven entry sequence
        for (int i = 0; i < 12; i++) begin
            sw = vecs[i].sw; sw_neg = vecs[i].neg;
            step(4);
            if (vecs[i].kind == 0) press(1'b1, 1'b0, 25);
            else                   press(1'b0, 1'b1, 25);
            check_all($sformatf("vec%0d", i), vecs[i].eA, vecs[i].eB, vecs[i].eop,
                      vecs[i].ev, vecs[i].ee, vecs[i].eph);
        end

        // bounce then long hold: exactly one advance (0 -> 1)
        sw = 4'd2; sw_neg = 1'b0; step(4);
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_next = ~btn_next;
            step(1);
        end
        btn_next = 1'b1; step(100);
        btn_next = 1'b0; step(30);
        check("bounce.changes", 32'(changes), 32'd1);
        check("bounce.phase", 32'(phase), 32'd1);
        check("bounce.A", 32'(A), 32'd2);

        // short press: no advance
        changes = 0;
        press(1'b1, 1'b0, 9);
        check("short.changes", 32'(changes), 32'd0);
        check("short.phase", 32'(phase), 32'd1);

        // reach ENTER_OP then clear and next together: clear wins
        sw = 4'd6; sw_neg = 1'b1; step(4);
        press(1'b1, 1'b0, 25);
        check("toop.phase", 32'(phase), 32'd2);
        press(1'b1, 1'b1, 25);
        check_all("clrprio", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);

        // to READY, then hold next 500 cycles: one transition, values retained
        sw = 4'd4; sw_neg = 1'b0; step(4);
        press(1'b1, 1'b0, 25);
        sw = 4'd1; sw_neg = 1'b1; step(4);
        press(1'b1, 1'b0, 25);
        sw = 4'd5; step(4);
        press(1'b1, 1'b0, 25);
        check_all("ready", 4'd4, 4'd15, 3'd5, 1'b1, 1'b0, 2'd3);
        changes = 0;
        press(1'b1, 1'b0, 500);
        check("hold500.changes", 32'(changes), 32'd1);
        check_all("hold500", 4'd4, 4'd15, 3'd5, 1'b0, 1'b0, 2'd0);

        // reset in ENTER_B with next mid-debounce; button held through release
        sw = 4'd2; sw_neg = 1'b0; step(4);
        press(1'b1, 1'b0, 25);
        check("rstpre.phase", 32'(phase), 32'd1);
        sw = 4'd3;
        btn_next = 1'b1;
        step(10);
        rst = 1'b1;
        #1;
        check_all("rst_async", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0);
        step(3);
        rst = 1'b0;
        last_ph = phase; changes = 0;
        step(60);
        check("rstheld.changes", 32'(changes), 32'd1);
        check_all("rstheld", 4'd3, 4'd0, 3'd0, 1'b0, 1'b0, 2'd1);
        btn_next = 1'b0; step(30);

        // randomized entries against the press-level model
        press(1'b0, 1'b1, 25);
        mA = 0; mB = 0; mop = 0; mv = 0; me = 0; mph = 0;
        for (int i = 0; i < 100; i++) begin
            int r;
            logic nx, cl;
            r  = $urandom_range(0, 9);
            cl = (r <= 1);
            nx = (r != 0);
            sw = 4'($urandom_range(0, 15));
            sw_neg = 1'($urandom_range(0, 1));
            step(4);
            press(nx, cl, 20 + $urandom_range(0, 10));
            model_press(nx, cl, sw, sw_neg);
            check_all($sformatf("rnd%0d", i), mA, mB, mop, mv, me, mph);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
